div5_bit_serializer: RTL and testbench



---
 rtl/div5_bit_serializer_if.sv | 51 +++++
 rtl/div5_bit_serializer.sv | 160 ++++++++++++++++
 tb/tb_div5_bit_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div5_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// div5_bit_serializer_if
//   Bundles the parallel-word input handshake, the serial-bit output handshake
//   and the status signals of div5_bit_serializer.
//
//   Handshake semantics (both streams): a transfer happens on a rising clk edge
//   where valid and ready are both 1. The producer holds data/valid stable
//   until the transfer happens; the consumer's ready may change at any time.
//   Input stream:  in_data/in_valid (producer = upstream), in_ready (block).
//   Output stream: bit_out/bit_valid/sof/eof (producer = block), out_ready.
//
//   Signals:
//     in_data    [WIDTH]  parallel word to serialize
//     in_valid            in_data valid
//     in_ready            block can accept a word this cycle
//     bit_out             current serial bit, MSB-first
//     bit_valid           bit_out valid
//     out_ready           downstream accepts bit_out this cycle
//     sof / eof           bit_out is the first / last bit of the word
//     busy                word in flight
//     word_count [CNT_W]  words fully shifted out, wraps
//     dbg_state           FSM state (0 = IDLE, 1 = SHIFT)
//
//   Modports: master = upstream/downstream side (testbench), slave = block.
// -----------------------------------------------------------------------------
interface div5_bit_serializer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             bit_out;
   logic             bit_valid;
   logic             out_ready;
   logic             sof;
   logic             eof;
   logic             busy;
   logic [CNT_W-1:0] word_count;
   logic             dbg_state;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, bit_out, bit_valid, sof, eof, busy, word_count, dbg_state
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, bit_out, bit_valid, sof, eof, busy, word_count, dbg_state
   );
endinterface

// File: rtl/div5_bit_serializer.sv
// -----------------------------------------------------------------------------
// div5_bit_serializer
//   Upstream feeder for the divide-by-five bit-serial checker. Accepts parallel
//   words over a valid/ready handshake and shifts them out MSB-first, one bit
//   per accepted output beat, flagging the first (sof) and last (eof) bit of
//   each word and counting completed words.
//
//   Ports:
//     clk    system clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset
//     ser    div5_bit_serializer_if.slave (data, handshakes, status)
//
//   Parameters:
//     WIDTH  data word width in bits (>= 1)
//     CNT_W  width of the completed-word counter
//
//   Optional feature (macro DIV5_SER_SKID_BUFFER_EN):
//     Adds a one-entry holding register so the next word can be accepted while
//     the current one is shifting, giving back-to-back words with no idle
//     cycle. Undefined: in_ready only in IDLE, WIDTH+1 cycles per word minimum.
//
//   Every output is decoded from registered state only; there is no
//   combinational path from in_valid or out_ready to any output.
// -----------------------------------------------------------------------------
module div5_bit_serializer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   div5_bit_serializer_if.slave ser
);

   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;
`ifdef DIV5_SER_SKID_BUFFER_EN
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic             hold_valid_q, hold_valid_d;
`endif

   logic in_ready;
   logic bit_valid;
   logic in_xfer;
   logic beat;
   logic is_last;

   assign in_xfer = ser.in_valid & in_ready;
   assign beat    = bit_valid & ser.out_ready;
   assign is_last = (bitcnt_q == '0);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         word_count_q <= '0;
`ifdef DIV5_SER_SKID_BUFFER_EN
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         word_count_q <= word_count_d;
`ifdef DIV5_SER_SKID_BUFFER_EN
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
`endif
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      word_count_d = word_count_q;
`ifdef DIV5_SER_SKID_BUFFER_EN
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               shreg_d  = ser.in_data;
               bitcnt_d = LAST_IDX;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
`ifdef DIV5_SER_SKID_BUFFER_EN
            if (in_xfer) begin
               hold_data_d  = ser.in_data;
               hold_valid_d = 1'b1;
            end
`endif
            if (beat) begin
               if (!is_last) begin
                  shreg_d  = shreg_q << 1;
                  bitcnt_d = bitcnt_q - BCW'(1);
               end else begin
                  word_count_d = word_count_q + CNT_W'(1);
`ifdef DIV5_SER_SKID_BUFFER_EN
                  // in_ready is !hold_valid, so a full holding register and a
                  // new input transfer can never coincide here.
                  if (hold_valid_q) begin
                     shreg_d      = hold_data_q;
                     bitcnt_d     = LAST_IDX;
                     hold_valid_d = 1'b0;
                  end else if (in_xfer) begin
                     // Word arriving on the eof beat goes straight into the
                     // shifter so it does not wait in the holding register.
                     shreg_d      = ser.in_data;
                     bitcnt_d     = LAST_IDX;
                     hold_valid_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
`else
                  state_d = IDLE;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      bit_valid = (state_q == SHIFT);
`ifdef DIV5_SER_SKID_BUFFER_EN
      in_ready  = !hold_valid_q;
`else
      in_ready  = (state_q == IDLE);
`endif
   end

   assign ser.in_ready   = in_ready;
   assign ser.bit_valid  = bit_valid;
   assign ser.bit_out    = bit_valid & shreg_q[WIDTH-1];
   assign ser.sof        = bit_valid & (bitcnt_q == LAST_IDX);
   assign ser.eof        = bit_valid & is_last;
   assign ser.busy       = bit_valid;
   assign ser.word_count = word_count_q;
   assign ser.dbg_state  = state_q;

endmodule

// File: tb/tb_div5_bit_serializer.sv
module tb_div5_bit_serializer;

   localparam int W = 8;
   localparam int CW = 8;
`ifdef DIV5_SER_SKID_BUFFER_EN
   localparam logic SHIFT_RDY = 1'b1;  // holding register empty while shifting
   localparam int   EXP_GAP   = 0;
   localparam logic TOG_VALID = 1'b0;  // a valid toggle would be accepted here
`else
   localparam logic SHIFT_RDY = 1'b0;
   localparam int   EXP_GAP   = 1;
   localparam logic TOG_VALID = 1'b1;
`endif

   logic clk;
   logic rst_n;

   div5_bit_serializer_if #(.WIDTH(W), .CNT_W(CW)) ser ();

   div5_bit_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ser   (ser)
   );

   // ------------------------------------------------------ clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;
   logic [CW-1:0] wc_model;
   logic [W-1:0]  exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ser.in_valid = 1'b0;
      ser.out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      wc_model = '0;
   endtask

   // ------------------------------------------------------------ driver tasks
   // Accepts one word (block must be idle) and follows it bit by bit. The
   // output stalls for stall_len cycles while bit number stall_at is shown.
   // With toggle set, in_data is scrambled every cycle while the word shifts.
   task automatic send_word(input logic [W-1:0] d, input int stall_at,
                            input int stall_len, input bit toggle);
      int b, stalls, guard;
      chk("send_in_ready", ser.in_ready, 1'b1);
      ser.in_data   = d;
      ser.in_valid  = 1'b1;
      ser.out_ready = 1'b1;
      tick();
      ser.in_valid = 1'b0;
      b = 0; stalls = 0; guard = 0;
      while (b < W && guard < 64) begin
         chk("ser_valid", ser.bit_valid, 1'b1);
         chk("ser_bit",   ser.bit_out,   d[W-1-b]);
         chk("ser_sof",   ser.sof,       (b == 0));
         chk("ser_eof",   ser.eof,       (b == W-1));
         chk("ser_busy",  ser.busy,      1'b1);
         chk("ser_ready", ser.in_ready,  SHIFT_RDY);
         if (b == stall_at && stalls < stall_len) begin
            ser.out_ready = 1'b0;
            stalls++;
         end else begin
            ser.out_ready = 1'b1;
            b++;
         end
         if (toggle) begin
            ser.in_data  = W'($urandom_range(0, 255));
            ser.in_valid = TOG_VALID;
         end
         tick();
         guard++;
      end
      ser.out_ready = 1'b1;
      ser.in_valid  = 1'b0;
      chk("ser_timeout", b, W);
      wc_model = wc_model + CW'(1);
      chk("post_valid", ser.bit_valid, 1'b0);
      chk("post_busy",  ser.busy,      1'b0);
      chk("post_wc",    ser.word_count, wc_model);
   endtask

   // ---------------------------------------------------------- vector table
   typedef struct {
      logic         rst_n;
      logic         in_valid;
      logic [W-1:0] in_data;
      logic         out_ready;
      logic         e_valid;
      logic         e_bit;
      logic         e_sof;
      logic         e_eof;
      logic         e_ready;
      logic         e_busy;
      logic [CW-1:0] e_wc;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [W-1:0] cur;
      int pos, gaps, sent;
      bit seen_eof, take;

      rst_n = 1'b0;
      ser.in_data = '0;
      ser.in_valid = 1'b0;
      ser.out_ready = 1'b1;
      wc_model = '0;

      // Basic word 8'hA5 after a two-cycle reset: bits 1,0,1,0,0,1,0,1.
      vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SHIFT_RDY, 1'b1, 8'd0};
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, SHIFT_RDY, 1'b1, 8'd0};
      vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};

      for (int i = 0; i < 11; i++) begin
         rst_n         = vecs[i].rst_n;
         ser.in_valid  = vecs[i].in_valid;
         ser.in_data   = vecs[i].in_data;
         ser.out_ready = vecs[i].out_ready;
         tick();
         chk($sformatf("vec%0d_valid", i), ser.bit_valid,  vecs[i].e_valid);
         chk($sformatf("vec%0d_bit", i),   ser.bit_out,    vecs[i].e_bit);
         chk($sformatf("vec%0d_sof", i),   ser.sof,        vecs[i].e_sof);
         chk($sformatf("vec%0d_eof", i),   ser.eof,        vecs[i].e_eof);
         chk($sformatf("vec%0d_ready", i), ser.in_ready,   vecs[i].e_ready);
         chk($sformatf("vec%0d_busy", i),  ser.busy,       vecs[i].e_busy);
         chk($sformatf("vec%0d_wc", i),    ser.word_count, vecs[i].e_wc);
      end
      ser.in_valid = 1'b0;
      wc_model = 8'd1;

      // Backpressure: 8'h0F stalled for three cycles on the third bit.
      send_word(8'h0F, 2, 3, 1'b0);

      // Input ignored while not ready: in_data scrambled mid-word.
      send_word(8'h3C, -1, 0, 1'b1);

      // Back-to-back 8'h05 then 8'h14 with in_valid held high.
      exp_q = {8'h05, 8'h14};
      pos = 0; gaps = 0; sent = 0; seen_eof = 1'b0;
      ser.in_data  = 8'h05;
      ser.in_valid = 1'b1;
      ser.out_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         take = ser.in_valid && ser.in_ready;
         tick();
         if (take) begin
            sent++;
            if (sent == 1) ser.in_data = 8'h14;
            else ser.in_valid = 1'b0;
         end
         if (ser.bit_valid) begin
            cur = exp_q[0];
            chk("b2b_bit", ser.bit_out, cur[W-1-pos]);
            chk("b2b_sof", ser.sof, (pos == 0));
            chk("b2b_eof", ser.eof, (pos == W-1));
            if (pos == 0 && seen_eof) chk("b2b_gap", gaps, EXP_GAP);
            if (pos == W-1) begin
               void'(exp_q.pop_front());
               pos = 0;
               gaps = 0;
               seen_eof = 1'b1;
            end else begin
               pos++;
            end
         end else if (seen_eof) begin
            gaps++;
         end
      end
      ser.in_valid = 1'b0;
      chk("b2b_timeout", exp_q.size(), 0);
      tick();
      wc_model = wc_model + CW'(2);
      chk("b2b_wc", ser.word_count, wc_model);
      chk("b2b_idle", ser.bit_valid, 1'b0);

      // Reset mid-word: 8'hFF, reset after three beats.
      ser.in_data  = 8'hFF;
      ser.in_valid = 1'b1;
      tick();
      ser.in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_busy_before", ser.busy, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("rst_valid", ser.bit_valid,  1'b0);
      chk("rst_busy",  ser.busy,       1'b0);
      chk("rst_wc",    ser.word_count, 8'd0);
      chk("rst_ready", ser.in_ready,   1'b1);
      chk("rst_eof",   ser.eof,        1'b0);
      rst_n = 1'b1;
      wc_model = '0;
      send_word(8'h0A, -1, 0, 1'b0);

      // Counter wrap: 256 words from a fresh reset.
      do_reset();
      for (int i = 0; i < 255; i++) send_word(W'(i), -1, 0, 1'b0);
      chk("wrap_255", ser.word_count, 8'd255);
      send_word(8'hC3, -1, 0, 1'b0);
      chk("wrap_0", ser.word_count, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
